serial_sub: RTL

//  Bit-serial subtractor, the inverse of the team's full-adder cell: computes

---
 rtl/serial_sub.sv | 103 ++++++++++
 1 files changed

// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first,
// through a single full-subtractor cell and a borrow flip-flop.
module serial_sub #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_sh, b_sh, diff_sh;
   logic [CW-1:0]    cnt;
   logic             br, a_msb, b_msb;
   logic             ai, bi, d, br_nx, last;

   // Full-subtractor cell on the current bit pair.
   assign ai    = a_sh[0];
   assign bi    = b_sh[0];
   assign d     = ai ^ bi ^ br;
   assign br_nx = (~ai & bi) | (~(ai ^ bi) & br);
   assign last  = (cnt == CW'(WIDTH - 1));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; blocking here would create ordering races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // NOTE: every comb output gets a default first so no latch is inferred.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid) state_nx = RUN;
         RUN:     if (last) state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      busy      = (state != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh    <= '0;
         b_sh    <= '0;
         diff_sh <= '0;
         cnt     <= '0;
         br      <= 1'b0;
         a_msb   <= 1'b0;
         b_msb   <= 1'b0;
         diff    <= '0;
         bout    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_sh  <= a;
               b_sh  <= b;
               br    <= bin;
               cnt   <= '0;
               a_msb <= a[WIDTH-1];
               b_msb <= b[WIDTH-1];
            end
            RUN: begin
               a_sh    <= a_sh >> 1;
               b_sh    <= b_sh >> 1;
               diff_sh <= {d, diff_sh[WIDTH-1:1]};
               br      <= br_nx;
               cnt     <= cnt + 1'b1;
               // Result registers update only on the final bit, so they hold
               // through DONE and after the return to IDLE.
               if (last) begin
                  diff <= {d, diff_sh[WIDTH-1:1]};
                  bout <= br_nx;
                  ovf  <= (a_msb != b_msb) && (d != a_msb);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
